// File: rtl/ffpmac_feeder_if.sv
// Wishbone classic slave bus bundle for the FFPMAC operand feeder.
interface ffpmac_feeder_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/ffpmac_feeder.sv
// Wishbone-slave operand sequencer: FIFOs {B,A} fp16 pairs into the FFPMAC core,
// optionally chaining each result back as the next addend.
module ffpmac_feeder #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned MAC_LAT    = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  ffpmac_feeder_if.slave       wbs,
  output logic [15:0]          mac_a,
  output logic [15:0]          mac_b,
  output logic [31:0]          mac_c,
  output logic [1:0]           mac_rnd,
  input  logic [31:0]          mac_result,
  output logic                 irq
);
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   wcnt_q;
  logic            ack_q, ack_d;
  logic [1:0]      rnd_q;
  logic            chain_q, irq_en_q, done_q, ovf_q, first_q;
  logic [31:0]     cinit_q, result_q, acc_q;
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic [31:0]     rdata;

  logic [2:0] idx;
  logic wr, wr_ctrl, wr_stat, wr_push, wr_cinit;
  logic start_req, clr, fifo_empty, fifo_full, push_ok;
  logic busy, pop, cap, run_start, empty_start;
  logic unused_bits;

  assign unused_bits = &{1'b0, wbs.wbs_sel_i, wbs.wbs_adr_i[7:5], wbs.wbs_adr_i[1:0]};

  assign ack_d      = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_q &
                      (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign idx        = wbs.wbs_adr_i[4:2];
  assign wr         = ack_q & wbs.wbs_we_i;
  assign wr_ctrl    = wr && (idx == 3'd0);
  assign wr_stat    = wr && (idx == 3'd1);
  assign wr_push    = wr && (idx == 3'd2);
  assign wr_cinit   = wr && (idx == 3'd3);
  assign clr        = wr_ctrl & wbs.wbs_dat_i[5];
  assign start_req  = wr_ctrl & wbs.wbs_dat_i[0] & ~wbs.wbs_dat_i[5];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign push_ok    = wr_push & ~fifo_full;
  assign irq        = done_q & irq_en_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start_req && !fifo_empty) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT:    if (wcnt_q == WW'(MAC_LAT - 1)) state_d = S_CAPTURE;
      S_CAPTURE: state_d = fifo_empty ? S_IDLE : S_ISSUE;
      default:   state_d = S_IDLE;
    endcase
    if (clr) state_d = S_IDLE;
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    pop         = (state_q == S_ISSUE) && !clr;
    cap         = (state_q == S_CAPTURE) && !clr;
    run_start   = (state_q == S_IDLE) && start_req && !fifo_empty;
    empty_start = (state_q == S_IDLE) && start_req && fifo_empty;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wcnt_q   <= '0;
      ack_q    <= 1'b0;
      rnd_q    <= '0;
      chain_q  <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      first_q  <= 1'b0;
      cinit_q  <= '0;
      result_q <= '0;
      acc_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      mac_a    <= '0;
      mac_b    <= '0;
      mac_c    <= '0;
      mac_rnd  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ack_q  <= ack_d;
      wcnt_q <= (state_q == S_WAIT) ? wcnt_q + WW'(1) : '0;

      if (wr_ctrl) begin
        rnd_q    <= wbs.wbs_dat_i[2:1];
        chain_q  <= wbs.wbs_dat_i[3];
        irq_en_q <= wbs.wbs_dat_i[4];
      end
      if (wr_cinit) cinit_q <= wbs.wbs_dat_i;

      // Priority: W1C < run-start clear < hardware set < clr.
      if (wr_stat && wbs.wbs_dat_i[1]) done_q <= 1'b0;
      if (run_start)                   done_q <= 1'b0;
      if (empty_start || (cap && fifo_empty)) done_q <= 1'b1;
      if (clr)                         done_q <= 1'b0;

      if (clr)                            ovf_q <= 1'b0;
      else if (wr_push && fifo_full)      ovf_q <= 1'b1;
      else if (wr_stat && wbs.wbs_dat_i[8]) ovf_q <= 1'b0;

      if (empty_start) result_q <= cinit_q;
      else if (cap)    result_q <= mac_result;

      if (clr)      acc_q <= '0;
      else if (cap) acc_q <= mac_result;

      if (run_start) first_q <= 1'b1;
      else if (pop)  first_q <= 1'b0;

      if (pop) begin
        mac_a   <= mem_q[rptr_q][15:0];
        mac_b   <= mem_q[rptr_q][31:16];
        mac_c   <= (first_q || !chain_q) ? cinit_q : acc_q;
        mac_rnd <= rnd_q;
      end

      if (clr) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push_ok) begin
          mem_q[wptr_q] <= wbs.wbs_dat_i;
          wptr_q        <= wptr_q + AW'(1);
        end
        if (pop) rptr_q <= rptr_q + AW'(1);
        case ({push_ok, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (idx)
      3'd0:    rdata = {27'b0, irq_en_q, chain_q, rnd_q, 1'b0};
      3'd1:    rdata = {23'b0, ovf_q, 4'(count_q), fifo_empty, fifo_full, done_q, busy};
      3'd3:    rdata = cinit_q;
      3'd4:    rdata = result_q;
      default: rdata = '0;
    endcase
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = (ack_q && !wbs.wbs_we_i) ? rdata : '0;
endmodule

// File: tb/tb_ffpmac_feeder.sv
// Directed bench for ffpmac_feeder with an integer A*B+C MAC stub pipeline.
module tb_ffpmac_feeder;
  localparam int unsigned MAC_LAT = 3;
  localparam logic [31:0] BASE    = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mac_a, mac_b;
  logic [31:0] mac_c, mac_result;
  logic [1:0]  mac_rnd;
  logic        irq;
  int          errors = 0;
  int          checks = 0;

  ffpmac_feeder_if bus ();

  ffpmac_feeder #(.BASE_ADDR(BASE), .MAC_LAT(MAC_LAT), .FIFO_DEPTH(4)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wbs(bus.slave),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_rnd(mac_rnd),
    .mac_result(mac_result), .irq(irq)
  );

  always #5 clk = ~clk;

  logic [31:0] pipe [MAC_LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAC_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {16'b0, mac_a} * {16'b0, mac_b} + mac_c;
      for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mac_result = pipe[MAC_LAT-1];

  typedef struct {
    logic        we;
    logic [7:0]  off;
    logic [31:0] wd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                    output logic [31:0] rd);
    logic got;
    got = 1'b0;
    rd  = '0;
    @(negedge clk);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = wd;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin got = 1'b1; rd = bus.wbs_dat_o; break; end
    end
    @(posedge clk); #1;
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    if (!got) chk("ack_timeout", 32'(got), 32'd1);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    wb(1'b1, BASE + 32'(off), d, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] r;
    wb(1'b0, BASE + 32'(off), '0, r);
    chk(name, r, exp);
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    wr(8'h08, {b, a});
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] r;
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      wb(1'b0, BASE + 32'h04, '0, r);
      if (!r[0]) begin ok = 1'b1; break; end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  vec_t tbl [12];

  initial begin
    logic sawack;
    int   n;
    tbl[0]  = '{1'b0, 8'h04, 32'h0,         32'h0000_0008, "rst_status"};
    tbl[1]  = '{1'b0, 8'h10, 32'h0,         32'h0,         "rst_result"};
    tbl[2]  = '{1'b0, 8'h14, 32'h0,         32'h0,         "unmapped_rd"};
    tbl[3]  = '{1'b1, 8'h0C, 32'h1234_5678, 32'h1234_5678, "cinit_rw"};
    tbl[4]  = '{1'b1, 8'h00, 32'h0000_001E, 32'h0000_001E, "ctrl_rw"};
    tbl[5]  = '{1'b1, 8'h00, 32'h0000_0021, 32'h0000_0000, "ctrl_clr_start"};
    tbl[6]  = '{1'b0, 8'h04, 32'h0,         32'h0000_0008, "clr_wins"};
    tbl[7]  = '{1'b1, 8'h08, 32'h0007_0009, 32'h0,         "push_reads0"};
    tbl[8]  = '{1'b0, 8'h04, 32'h0,         32'h0000_0010, "count1"};
    tbl[9]  = '{1'b1, 8'h00, 32'h0000_0020, 32'h0000_0000, "clr_ctrl"};
    tbl[10] = '{1'b1, 8'h10, 32'hDEAD_BEEF, 32'h0,         "result_ro"};
    tbl[11] = '{1'b1, 8'h14, 32'hDEAD_BEEF, 32'h0,         "unmapped_wr"};

    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = '0;   bus.wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {bus.wbs_ack_o, irq, mac_rnd, mac_a, mac_c[11:0]}, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // Miss: no ack for several cycles
    @(negedge clk);
    bus.wbs_stb_i = 1'b1; bus.wbs_cyc_i = 1'b1; bus.wbs_adr_i = 32'h4000_0004;
    sawack = 1'b0;
    repeat (6) begin @(negedge clk); if (bus.wbs_ack_o) sawack = 1'b1; end
    bus.wbs_stb_i = 1'b0; bus.wbs_cyc_i = 1'b0;
    chk("miss_no_ack", 32'(sawack), 32'd0);

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].we) begin
        wr(tbl[i].off, tbl[i].wd);
        rd_chk(tbl[i].name, tbl[i].off, tbl[i].exp);
      end else begin
        rd_chk(tbl[i].name, tbl[i].off, tbl[i].exp);
      end
    end

    // Chain run with irq: 5+2*3=11, 11+4*5=31, 31+1*7=38
    wr(8'h0C, 32'd5);
    push(16'd2, 16'd3); push(16'd4, 16'd5); push(16'd1, 16'd7);
    wr(8'h00, 32'h0000_001D);
    n = 0;
    while (!irq && n < 100) begin @(posedge clk); #1; n++; end
    chk("chain_cycles", 32'(n), 32'(3 * (MAC_LAT + 2)));
    chk("chain_irq", 32'(irq), 32'd1);
    chk("chain_last_ops", {mac_a, mac_b}, {16'd1, 16'd7});
    chk("chain_last_c", mac_c, 32'd31);
    chk("chain_rnd", 32'(mac_rnd), 32'd2);
    rd_chk("chain_result", 8'h10, 32'd38);
    rd_chk("chain_status", 8'h04, 32'h0000_000A);
    wr(8'h04, 32'h0000_0002);
    #1 chk("w1c_irq_low", 32'(irq), 32'd0);

    // Non-chain: each pair uses C_INIT, last = 4*4+10
    wr(8'h0C, 32'd10);
    push(16'd2, 16'd3); push(16'd4, 16'd4);
    wr(8'h00, 32'h0000_0001);
    wait_idle("nochain_idle");
    rd_chk("nochain_result", 8'h10, 32'd26);
    chk("nochain_irq", 32'(irq), 32'd0);
    rd_chk("nochain_status", 8'h04, 32'h0000_000A);

    // Overflow, W1C ovf, clr then empty start
    for (int i = 0; i < 5; i++) push(16'(i + 1), 16'd1);
    rd_chk("ovf_status", 8'h04, 32'h0000_0146);
    wr(8'h04, 32'h0000_0100);
    rd_chk("ovf_w1c", 8'h04, 32'h0000_0046);
    wr(8'h00, 32'h0000_0020);
    rd_chk("clr_status", 8'h04, 32'h0000_0008);
    rd_chk("clr_keeps_result", 8'h10, 32'd26);
    wr(8'h0C, 32'h0000_ABCD);
    wr(8'h00, 32'h0000_0001);
    rd_chk("empty_start_status", 8'h04, 32'h0000_000A);
    rd_chk("empty_start_result", 8'h10, 32'h0000_ABCD);

    // Push during WAIT is consumed: 0+1*1=1, 1+3*3=10
    wr(8'h04, 32'h0000_0002);
    wr(8'h0C, 32'd0);
    push(16'd1, 16'd1);
    wr(8'h00, 32'h0000_0009);
    push(16'd3, 16'd3);
    wait_idle("midpush_idle");
    rd_chk("midpush_result", 8'h10, 32'd10);

    // clr during WAIT: no capture, flushed
    wr(8'h04, 32'h0000_0002);
    push(16'd2, 16'd2); push(16'd1, 16'd1);
    wr(8'h00, 32'h0000_0001);
    wr(8'h00, 32'h0000_0020);
    rd_chk("abort_status", 8'h04, 32'h0000_0008);
    repeat (12) @(posedge clk);
    rd_chk("abort_no_capture", 8'h10, 32'd10);

    // Async reset mid-run
    wr(8'h0C, 32'd7);
    push(16'd5, 16'd6);
    wr(8'h00, 32'h0000_0005);
    @(posedge clk); #1;
    chk("prerst_ops", {mac_a, mac_b}, {16'd5, 16'd6});
    chk("prerst_c", mac_c, 32'd7);
    chk("prerst_rnd", 32'(mac_rnd), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mac", {mac_a, mac_b}, 32'h0);
    chk("async_rst_c", mac_c, 32'h0);
    chk("async_rst_misc", {29'b0, mac_rnd, irq}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) @(posedge clk);
    rd_chk("postrst_status", 8'h04, 32'h0000_0008);
    rd_chk("postrst_result", 8'h10, 32'h0);
    rd_chk("postrst_cinit", 8'h0C, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
